// File: rtl/serial_add_arbiter.sv
// Round-robin front-end sharing one bit-serial add/subtract datapath among NREQ requesters.
// A granted request is shifted LSB-first through a single carry flop for WIDTH cycles, and
// the result is held on a valid/ready response channel together with the requester index.
module serial_add_arbiter #(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  NREQ  = 4,
  localparam int unsigned ID_W  = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*WIDTH-1:0]   req_a_i,
  input  logic [NREQ*WIDTH-1:0]   req_b_i,
  input  logic [NREQ-1:0]         req_sub_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [WIDTH-1:0]        rsp_sum_o,
  output logic                    rsp_cout_o,
  output logic                    busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              cout_q, cout_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              sum_bit, carry_next;

  // (base + off) mod NREQ, valid for off < NREQ; handles non-power-of-two NREQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[ID_W-1:0];
  endfunction

  // Round-robin search starting at rr_ptr_q; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid_i[rr_index(rr_ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_index(rr_ptr_q, k);
      end
    end
  end

  assign sel_a      = req_a_i[gnt_idx*WIDTH +: WIDTH];
  assign sel_b      = req_b_i[gnt_idx*WIDTH +: WIDTH];
  assign sum_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign carry_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; a grant in IDLE is always a handshake since ready implies valid.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_found)       state_d = StShift;
      StShift: if (count_q == '0)   state_d = StDone;
      StDone:  if (rsp_ready_i)     state_d = StIdle;
      default:                      state_d = StIdle;
    endcase
  end

  // FSM outputs; no grant outside IDLE, so a response handshake cannot overlap a grant.
  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && gnt_found) req_ready_o[gnt_idx] = 1'b1;
    rsp_valid_o = (state_q == StDone);
    busy_o      = (state_q != StIdle);
  end

  // Datapath next-state: operand capture on grant, one serial bit per SHIFT cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    id_d     = id_q;
    cout_d   = cout_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          a_sh_d   = sel_a;
          // Subtract as A + ~B + 1: invert B here and seed the carry with 1.
          b_sh_d   = req_sub_i[gnt_idx] ? ~sel_b : sel_b;
          carry_d  = req_sub_i[gnt_idx];
          id_d     = gnt_idx;
          rr_ptr_d = rr_index(gnt_idx, 1);
          count_d  = CntW'(WIDTH - 1);
        end
      end
      StShift: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = carry_next;
        if (count_q == '0) cout_d = carry_next;
        else               count_d = count_q - CntW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      id_q     <= '0;
      cout_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      id_q     <= id_d;
      cout_q   <= cout_d;
    end
  end

  assign rsp_id_o   = id_q;
  assign rsp_sum_o  = res_q;
  assign rsp_cout_o = cout_q;

endmodule
